// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp sequencer state encoding, also reused by the
// core's status logic.
package pwm_pkg;

   localparam int PWM_RAMP_STATE_W = 2;

   typedef enum logic [PWM_RAMP_STATE_W-1:0] {
      PWM_RAMP_IDLE = 2'd0,
      PWM_RAMP_RAMP = 2'd1,
      PWM_RAMP_RUN  = 2'd2,
      PWM_RAMP_STOP = 2'd3
   } pwm_ramp_state_e;

endpackage

// File: rtl/pwm_step_div.sv
// Overflow divider: emits a step pulse on every max(div_i,1)-th counter
// overflow so the ramp advances at a programmable rate.
module pwm_step_div #(
   parameter int DIV_W = 8
) (
   input  logic             clk_psc_i,
   input  logic             rst_n_i,
   input  logic             overflow_i,
   input  logic             clr_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             step_o
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] last_count;

   // Using >= lets a shrinking div_i fire at the very next overflow.
   assign last_count = (div_i == '0) ? '0 : div_i - 1'b1;
   assign step_o     = overflow_i & (count_q >= last_count);

   always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else if (clr_i || step_o) begin
         count_q <= '0;
      end else if (overflow_i) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: walks the channel compare-end value toward
// its goal in rate-limited, saturating steps and gates the counter enable.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIV_W = 8
) (
   input  logic             clk_psc_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             fault_i,
   input  logic             overflow_i,
   input  logic [WIDTH-1:0] target_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             cnt_en_o,
   output logic [WIDTH-1:0] cmp_end_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             fault_o,
   output logic [1:0]       state_o
);

   pwm_ramp_state_e  state_q, nxt_state;
   logic [WIDTH-1:0] cmp_q, nxt_cmp, goal, stepped;
   logic             cnt_en_q, nxt_cnt_en;
   logic             busy_q, done_q, nxt_done;
   logic             fault_q, nxt_fault;
   logic             step_ev, div_clr;

   // One extra bit keeps the sum/difference from wrapping before the clamp.
   function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] tgt,
                                                    input logic [WIDTH-1:0] inc);
      logic [WIDTH:0] sum;
      logic [WIDTH:0] diff;
      sum  = {1'b0, cur} + {1'b0, inc};
      diff = {1'b0, cur} - {1'b0, inc};
      step_toward = tgt;
      if (inc != '0) begin
         if (cur < tgt && sum < {1'b0, tgt}) begin
            step_toward = sum[WIDTH-1:0];
         end else if (cur > tgt && !diff[WIDTH] && diff[WIDTH-1:0] > tgt) begin
            step_toward = diff[WIDTH-1:0];
         end
      end
   endfunction

   assign goal    = (state_q == PWM_RAMP_STOP) ? '0 : target_i;
   assign stepped = step_toward(cmp_q, goal, step_i);
   assign div_clr = fault_i | (nxt_state != state_q);

   pwm_step_div #(.DIV_W(DIV_W)) u_step_div (
      .clk_psc_i  (clk_psc_i),
      .rst_n_i    (rst_n_i),
      .overflow_i (overflow_i & cnt_en_q),
      .clr_i      (div_clr),
      .div_i      (div_i),
      .step_o     (step_ev)
   );

   always_comb begin
      nxt_state  = state_q;
      nxt_cmp    = cmp_q;
      nxt_cnt_en = cnt_en_q;
      nxt_done   = 1'b0;
      nxt_fault  = fault_q;
      if (fault_i) begin
         nxt_state  = PWM_RAMP_IDLE;
         nxt_cmp    = '0;
         nxt_cnt_en = 1'b0;
         nxt_fault  = 1'b1;
      end else begin
         case (state_q)
            PWM_RAMP_IDLE: begin
               if (start_i && !stop_i) begin
                  nxt_state  = PWM_RAMP_RAMP;
                  nxt_cnt_en = 1'b1;
                  nxt_fault  = 1'b0;
               end
            end
            PWM_RAMP_RAMP: begin
               if (stop_i) begin
                  nxt_state = PWM_RAMP_STOP;
               end else if (step_ev) begin
                  nxt_cmp = stepped;
                  if (stepped == goal) begin
                     nxt_state = PWM_RAMP_RUN;
                     nxt_done  = 1'b1;
                  end
               end
            end
            PWM_RAMP_RUN: begin
               if (stop_i) begin
                  nxt_state = PWM_RAMP_STOP;
               end else if (target_i != cmp_q) begin
                  nxt_state = PWM_RAMP_RAMP;
               end
            end
            PWM_RAMP_STOP: begin
               // Disable only once a full period has already run at zero duty.
               if (start_i && !stop_i) begin
                  nxt_state = PWM_RAMP_RAMP;
               end else if (step_ev) begin
                  if (cmp_q == '0) begin
                     nxt_state  = PWM_RAMP_IDLE;
                     nxt_cnt_en = 1'b0;
                     nxt_done   = 1'b1;
                  end else begin
                     nxt_cmp = stepped;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= PWM_RAMP_IDLE;
         cmp_q    <= '0;
         cnt_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= nxt_state;
         cmp_q    <= nxt_cmp;
         cnt_en_q <= nxt_cnt_en;
         busy_q   <= (nxt_state == PWM_RAMP_RAMP) || (nxt_state == PWM_RAMP_STOP);
         done_q   <= nxt_done;
         fault_q  <= nxt_fault;
      end
   end

   assign cnt_en_o  = cnt_en_q;
   assign cmp_end_o = cmp_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign fault_o   = fault_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pwm_ramp_ctrl;

   localparam int WIDTH = 16;
   localparam int DIV_W = 8;

   logic             clk_psc_i = 1'b0;
   logic             rst_n_i = 1'b0;
   logic             start_i = 1'b0, stop_i = 1'b0, fault_i = 1'b0, overflow_i = 1'b0;
   logic [WIDTH-1:0] target_i = '0, step_i = '0;
   logic [DIV_W-1:0] div_i = '0;
   logic             cnt_en_o, busy_o, done_o, fault_o;
   logic [WIDTH-1:0] cmp_end_o;
   logic [1:0]       state_o;

   int checks = 0;
   int fails = 0;

   // Behavioural model: plain integers, state 0=idle 1=ramp 2=run 3=stop.
   int m_state, m_cmp, m_div;
   bit m_en, m_done, m_fault;

   pwm_ramp_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk_psc_i (clk_psc_i),
      .rst_n_i   (rst_n_i),
      .start_i   (start_i),
      .stop_i    (stop_i),
      .fault_i   (fault_i),
      .overflow_i(overflow_i),
      .target_i  (target_i),
      .step_i    (step_i),
      .div_i     (div_i),
      .cnt_en_o  (cnt_en_o),
      .cmp_end_o (cmp_end_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .fault_o   (fault_o),
      .state_o   (state_o)
   );

   always #5 clk_psc_i = ~clk_psc_i;

   function automatic int toward(int c, int g, int s);
      if (s == 0) return g;
      if (c < g) return (c + s > g) ? g : c + s;
      if (c > g) return (c - s < g) ? g : c - s;
      return g;
   endfunction

   task automatic model_step();
      int goal, d, ns, nc;
      bit en, ovf_ok, ev;
      goal = (m_state == 3) ? 0 : int'(target_i);
      d = (div_i == 0) ? 1 : int'(div_i);
      ovf_ok = overflow_i && m_en;
      ev = ovf_ok && (m_div >= d - 1);
      ns = m_state; nc = m_cmp; en = m_en;
      m_done = 0;
      if (fault_i) begin
         ns = 0; nc = 0; en = 0; m_fault = 1;
      end else if (m_state == 0) begin
         if (start_i && !stop_i) begin ns = 1; en = 1; m_fault = 0; end
      end else if (m_state == 1) begin
         if (stop_i) ns = 3;
         else if (ev) begin
            nc = toward(m_cmp, goal, int'(step_i));
            if (nc == goal) begin ns = 2; m_done = 1; end
         end
      end else if (m_state == 2) begin
         if (stop_i) ns = 3;
         else if (int'(target_i) != m_cmp) ns = 1;
      end else begin
         if (start_i && !stop_i) ns = 1;
         else if (ev) begin
            if (m_cmp == 0) begin ns = 0; en = 0; m_done = 1; end
            else nc = toward(m_cmp, 0, int'(step_i));
         end
      end
      if (fault_i || ns != m_state || ev) m_div = 0;
      else if (ovf_ok) m_div = m_div + 1;
      m_state = ns; m_cmp = nc; m_en = en;
   endtask

   task automatic drive(input bit st, input bit sp, input bit ft, input bit ov);
      start_i = st; stop_i = sp; fault_i = ft; overflow_i = ov;
      model_step();
      @(posedge clk_psc_i);
      #1;
      start_i = 0; stop_i = 0; overflow_i = 0;
   endtask

   task automatic apply_reset();
      rst_n_i = 0;
      start_i = 0; stop_i = 0; fault_i = 0; overflow_i = 0;
      m_state = 0; m_cmp = 0; m_div = 0; m_en = 0; m_done = 0; m_fault = 0;
      repeat (2) @(posedge clk_psc_i);
      #1 rst_n_i = 1;
   endtask

   task automatic ovf_step(input int exp_cmp, input int exp_state, input bit exp_done);
      drive(0, 0, 0, 1);
      checks++;
      if (cmp_end_o !== exp_cmp[WIDTH-1:0] || state_o !== exp_state[1:0] || done_o !== exp_done) begin
         fails++;
         $display("[TB] FAIL ovf_step: cmp=%0d state=%0d done=%0b required cmp=%0d state=%0d done=%0b",
                  cmp_end_o, state_o, done_o, exp_cmp, exp_state, exp_done);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({cnt_en_o, cmp_end_o, busy_o, done_o, fault_o, state_o} !== '0) begin
         fails++;
         $display("[TB] FAIL reset: en=%0b cmp=%0d busy=%0b done=%0b fault=%0b state=%0d required all 0",
                  cnt_en_o, cmp_end_o, busy_o, done_o, fault_o, state_o);
      end
   endtask

   task automatic test_ramp_up();
      apply_reset();
      target_i = 100; step_i = 30; div_i = 1;
      drive(1, 0, 0, 0);
      checks++;
      if (state_o !== 2'd1 || cnt_en_o !== 1'b1 || busy_o !== 1'b1 || cmp_end_o !== 0) begin
         fails++;
         $display("[TB] FAIL ramp_start: state=%0d en=%0b busy=%0b cmp=%0d required 1 1 1 0",
                  state_o, cnt_en_o, busy_o, cmp_end_o);
      end
      ovf_step(30, 1, 0);
      ovf_step(60, 1, 0);
      ovf_step(90, 1, 0);
      ovf_step(100, 2, 1);
      drive(0, 0, 0, 0);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || state_o !== 2'd2) begin
         fails++;
         $display("[TB] FAIL ramp_run_hold: done=%0b busy=%0b state=%0d required 0 0 2",
                  done_o, busy_o, state_o);
      end
   endtask

   task automatic test_divider();
      apply_reset();
      target_i = 20; step_i = 10; div_i = 3;
      drive(1, 0, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         drive(0, 0, 0, 0);
         ovf_step((i < 3) ? 0 : (i < 6) ? 10 : 20, (i < 6) ? 1 : 2, i == 6);
      end
      apply_reset();
      div_i = 0;
      drive(1, 0, 0, 0);
      ovf_step(10, 1, 0);
      ovf_step(20, 2, 1);
      apply_reset();
      target_i = 100; div_i = 5;
      drive(1, 0, 0, 0);
      ovf_step(0, 1, 0);
      ovf_step(0, 1, 0);
      ovf_step(0, 1, 0);
      div_i = 2;
      ovf_step(10, 1, 0);
   endtask

   task automatic test_stop();
      apply_reset();
      target_i = 100; step_i = 30; div_i = 1;
      drive(1, 0, 0, 0);
      repeat (4) drive(0, 0, 0, 1);
      step_i = 40;
      drive(0, 1, 0, 0);
      checks++;
      if (state_o !== 2'd3 || cmp_end_o !== 100 || busy_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL stop_enter: state=%0d cmp=%0d busy=%0b required 3 100 1",
                  state_o, cmp_end_o, busy_o);
      end
      ovf_step(60, 3, 0);
      ovf_step(20, 3, 0);
      ovf_step(0, 3, 0);
      checks++;
      if (cnt_en_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL stop_zero_en: en=%0b required 1", cnt_en_o);
      end
      ovf_step(0, 0, 1);
      checks++;
      if (cnt_en_o !== 1'b0 || busy_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL stop_disable: en=%0b busy=%0b required 0 0", cnt_en_o, busy_o);
      end
      ovf_step(0, 0, 0);
   endtask

   task automatic test_retarget_restart();
      apply_reset();
      target_i = 100; step_i = 30; div_i = 1;
      drive(1, 0, 0, 0);
      repeat (4) drive(0, 0, 0, 1);
      target_i = 50;
      drive(0, 0, 0, 0);
      checks++;
      if (state_o !== 2'd1 || cmp_end_o !== 100) begin
         fails++;
         $display("[TB] FAIL retarget_enter: state=%0d cmp=%0d required 1 100", state_o, cmp_end_o);
      end
      ovf_step(70, 1, 0);
      ovf_step(50, 2, 1);
      drive(0, 1, 0, 0);
      ovf_step(20, 3, 0);
      drive(1, 0, 0, 0);
      checks++;
      if (state_o !== 2'd1 || cmp_end_o !== 20) begin
         fails++;
         $display("[TB] FAIL restart: state=%0d cmp=%0d required 1 20", state_o, cmp_end_o);
      end
      ovf_step(50, 2, 1);
   endtask

   task automatic test_saturation();
      apply_reset();
      target_i = 16'hFFFF; step_i = 16'h8000; div_i = 1;
      drive(1, 0, 0, 0);
      ovf_step(16'h8000, 1, 0);
      ovf_step(16'hFFFF, 2, 1);
      step_i = 0; target_i = 500;
      drive(0, 0, 0, 0);
      ovf_step(500, 2, 1);
   endtask

   task automatic test_fault();
      apply_reset();
      target_i = 100; step_i = 30; div_i = 1;
      drive(1, 0, 0, 0);
      ovf_step(30, 1, 0);
      drive(0, 0, 1, 1);
      checks++;
      if (cnt_en_o !== 1'b0 || cmp_end_o !== 0 || fault_o !== 1'b1 || state_o !== 2'd0) begin
         fails++;
         $display("[TB] FAIL fault_shutdown: en=%0b cmp=%0d fault=%0b state=%0d required 0 0 1 0",
                  cnt_en_o, cmp_end_o, fault_o, state_o);
      end
      drive(1, 0, 1, 0);
      checks++;
      if (state_o !== 2'd0 || fault_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL fault_start_ignored: state=%0d fault=%0b required 0 1", state_o, fault_o);
      end
      fault_i = 0;
      drive(0, 0, 0, 0);
      checks++;
      if (fault_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL fault_sticky: fault=%0b required 1", fault_o);
      end
      drive(1, 0, 0, 0);
      checks++;
      if (fault_o !== 1'b0 || state_o !== 2'd1 || cnt_en_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL fault_clear: fault=%0b state=%0d en=%0b required 0 1 1",
                  fault_o, state_o, cnt_en_o);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      target_i = 100; step_i = 30; div_i = 1;
      drive(1, 1, 0, 0);
      checks++;
      if (state_o !== 2'd0 || cnt_en_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL idle_start_stop: state=%0d en=%0b required 0 0", state_o, cnt_en_o);
      end
      drive(1, 0, 0, 0);
      repeat (4) drive(0, 0, 0, 1);
      drive(1, 1, 0, 0);
      checks++;
      if (state_o !== 2'd3 || cmp_end_o !== 100) begin
         fails++;
         $display("[TB] FAIL run_start_stop: state=%0d cmp=%0d required 3 100", state_o, cmp_end_o);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      target_i = 100; step_i = 30; div_i = 1;
      drive(1, 0, 0, 0);
      ovf_step(30, 1, 0);
      #2 rst_n_i = 0;
      #1;
      checks++;
      if ({cnt_en_o, cmp_end_o, busy_o, done_o, fault_o, state_o} !== '0) begin
         fails++;
         $display("[TB] FAIL async_reset: en=%0b cmp=%0d busy=%0b state=%0d required all 0",
                  cnt_en_o, cmp_end_o, busy_o, state_o);
      end
      apply_reset();
   endtask

   task automatic test_random();
      apply_reset();
      target_i = 120; step_i = 25; div_i = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 40 == 0) begin
            target_i = WIDTH'($urandom_range(0, 300));
            step_i   = WIDTH'($urandom_range(0, 60));
            div_i    = DIV_W'($urandom_range(0, 3));
         end
         drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
               $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 35);
         checks++;
         if (cmp_end_o !== m_cmp[WIDTH-1:0] || state_o !== m_state[1:0] || cnt_en_o !== m_en) begin
            fails++;
            $display("[TB] FAIL random_core cyc %0d: cmp=%0d state=%0d en=%0b required %0d %0d %0b",
                     i, cmp_end_o, state_o, cnt_en_o, m_cmp, m_state, m_en);
         end
         checks++;
         if (done_o !== m_done || fault_o !== m_fault || busy_o !== (m_state == 1 || m_state == 3)) begin
            fails++;
            $display("[TB] FAIL random_flags cyc %0d: done=%0b fault=%0b busy=%0b required %0b %0b %0b",
                     i, done_o, fault_o, busy_o, m_done, m_fault, (m_state == 1 || m_state == 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_divider();
      test_stop();
      test_retarget_restart();
      test_saturation();
      test_fault();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Soft-start/soft-stop sequencer for one channel of the PWM core.
- Drives the core's counter enable and the channel's compare-end value.
- Steps the compare-end value toward a target once every N counter overflows, so duty changes are rate-limited and begin/end at zero duty.
- Sits between the register file and the PWM core; consumes the core's overflow (update event) pulse.

Parameters:
- WIDTH, 16, width of compare/target/step values (matches core counter width).
- DIV_W, 8, width of the overflow-divider count (periods per step).

Ports:
- clk_psc_i  input  1  PWM core clock.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  single-cycle request to start or restart ramping.
- stop_i  input  1  single-cycle request to ramp to zero and disable.
- fault_i  input  1  level; immediate shutdown.
- overflow_i  input  1  single-cycle update-event pulse from the PWM counter.
- target_i  input  WIDTH  desired compare-end value; sampled live.
- step_i  input  WIDTH  increment per step; 0 means jump straight to the goal.
- div_i  input  DIV_W  overflows per step; 0 is treated as 1.
- cnt_en_o  output  1  counter enable to the PWM core.
- cmp_end_o  output  WIDTH  compare-end value to the channel comparator.
- busy_o  output  1  high in RAMP or STOP.
- done_o  output  1  one-cycle pulse when the goal is reached (RAMP->RUN, or STOP->IDLE).
- fault_o  output  1  sticky fault flag; cleared by start_i while fault_i is low.
- state_o  output  2  current state, for debug/status.

Behaviour:
- Reset (async, rst_n_i low): state IDLE; all outputs 0; divider count 0.
- All outputs are registered.
- State encoding: IDLE=0, RAMP=1, RUN=2, STOP=3.
- Goal value: target_i in RAMP/RUN; 0 in STOP.
- Step event = overflow_i high while the divider count equals max(div_i,1)-1.
  - On a step event the divider count clears; on any other overflow_i it increments.
  - The divider count also clears on every state change.
- Step arithmetic uses WIDTH+1 bits; the result saturates at the goal and never overshoots or wraps.
  - cmp < goal: cmp = min(cmp+step, goal).
  - cmp > goal: cmp = max(cmp-step, goal).
  - step_i=0: cmp = goal.
- cmp_end_o updates on the clock edge that samples the step event (one-cycle latency from overflow_i). The core latches the new value at its next update event.
- IDLE:
  - cnt_en_o=0, cmp_end_o=0.
  - start_i -> RAMP, with cnt_en_o=1 from the next cycle.
- RAMP:
  - Steps toward the goal.
  - On the step event whose result equals the goal: -> RUN, done_o pulses in the same cycle cmp_end_o reaches the goal.
  - If target_i already equals cmp_end_o on entry, the transition happens on the first step event.
- RUN:
  - Holds cmp_end_o.
  - target_i != cmp_end_o -> RAMP (either direction).
- STOP:
  - Steps toward 0, cnt_en_o stays 1.
  - On the step event at which cmp_end_o is already 0: cnt_en_o=0, -> IDLE, done_o pulses. This guarantees at least one full zero-duty period before disable.
- Request priority:
  - stop_i in RAMP or RUN -> STOP, keeping the current cmp.
  - start_i in STOP -> RAMP from the current cmp; no discontinuity.
  - start_i in RAMP or RUN is ignored.
  - stop_i in IDLE is ignored.
  - start_i and stop_i in the same cycle: stop_i wins; in IDLE both are ignored.
- Fault:
  - fault_i high in any state: next cycle cnt_en_o=0, cmp_end_o=0, state IDLE, fault_o=1, divider cleared.
  - fault_i has priority over start/stop/step.
  - While fault_i is high, start_i is ignored.
  - start_i with fault_i low clears fault_o and enters RAMP.
- overflow_i while cnt_en_o=0 is ignored.
- Changes to div_i take effect on the next comparison.
- A div_i decrease below the current count forces a step event at the next overflow (compare uses count >= max(div_i,1)-1).

Decomposition:
- Shared package pwm_pkg: state encoding constants (PWM_RAMP_IDLE/RAMP/RUN/STOP) and the 2-bit state typedef; the core's status logic reuses them.
- One sub-module pwm_step_div:
  - Overflow divider with inputs overflow_i, clr_i, div_i.
  - Output step_o (combinational pulse qualified by overflow_i).
- Saturating step arithmetic and the FSM stay in the top module.

Test Plan:
- Basic ramp-up: target=100, step=30, div=1, start → cmp 30,60,90,100 on successive overflows; done_o pulse with cmp=100; state RUN.
- Divider: div=3, step=10, target=20 → cmp changes only on overflows 3 and 6; div=0 behaves as div=1.
- Stop: from RUN at cmp=100 with step=40, stop → cmp 60,20,0, then cnt_en_o=0 on the next overflow; done_o pulses; state IDLE.
- Retarget and restart: in RUN at 100, target=50, step=30 → 70,50, RUN. Then stop at 50 and start after one step (cmp=20) → ramps up from 20, never returns to 0.
- Saturation and step=0: target=0xFFFF, step=0x8000 → 0x8000,0xFFFF with no wrap. step=0, target=500 → cmp=500 on the first step event.
- Fault and simultaneity:
  - fault_i mid-RAMP → next cycle cnt_en_o=0, cmp=0, fault_o=1.
  - start while fault_i high → ignored; start after fault_i drops → fault_o=0 and RAMP.
  - start+stop in the same cycle in RUN → STOP.
  - Async reset mid-RAMP → all outputs 0 immediately.
